// File: rtl/obb_top_level.sv
`default_nettype none
// ============================================================================
//  Module   : obb_top_level
//  Purpose  : Streaming bounding-box corner generator. Collects a frame of
//             NPTS signed 3-D points (one per clock), tracks the per-axis
//             minimum and maximum, then registers the 8 corner vertices of
//             the enclosing box as sign-extended OW-bit coordinates.
//  Ports    : clk                       rising-edge clock
//             rst                       synchronous active-high reset
//             data_in_x/y/z   [IW-1:0]  signed point coordinates
//             data_out_xK/yK/zK [OW-1:0] corner K (1..8) coordinates, registered
//  Config   : OBB_CONTINUOUS_EN - when defined, the block returns to COLLECT
//             after each OUTPUT cycle instead of holding until reset.
//  Revision : 1.0  initial release
// ============================================================================
module obb_top_level #(
   parameter int NPTS = 16,
   parameter int IW   = 10,
   parameter int OW   = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] data_in_x,
   input  logic [IW-1:0] data_in_y,
   input  logic [IW-1:0] data_in_z,
   output logic [OW-1:0] data_out_x1, output logic [OW-1:0] data_out_y1, output logic [OW-1:0] data_out_z1,
   output logic [OW-1:0] data_out_x2, output logic [OW-1:0] data_out_y2, output logic [OW-1:0] data_out_z2,
   output logic [OW-1:0] data_out_x3, output logic [OW-1:0] data_out_y3, output logic [OW-1:0] data_out_z3,
   output logic [OW-1:0] data_out_x4, output logic [OW-1:0] data_out_y4, output logic [OW-1:0] data_out_z4,
   output logic [OW-1:0] data_out_x5, output logic [OW-1:0] data_out_y5, output logic [OW-1:0] data_out_z5,
   output logic [OW-1:0] data_out_x6, output logic [OW-1:0] data_out_y6, output logic [OW-1:0] data_out_z6,
   output logic [OW-1:0] data_out_x7, output logic [OW-1:0] data_out_y7, output logic [OW-1:0] data_out_z7,
   output logic [OW-1:0] data_out_x8, output logic [OW-1:0] data_out_y8, output logic [OW-1:0] data_out_z8
);

   localparam int            CW       = $clog2(NPTS);
   localparam int            EXT      = OW - IW;
   localparam logic [CW-1:0] LAST_CNT = CW'(NPTS - 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      OUTPUT  = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t        state, next_state;
   logic [CW-1:0] cnt;
   logic          take_sample;
   logic          load_out;

   logic signed [IW-1:0] min_x, max_x, min_y, max_y, min_z, max_z;
   logic [OW-1:0] cx [0:7];
   logic [OW-1:0] cy [0:7];
   logic [OW-1:0] cz [0:7];

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state <= COLLECT;
      else     state <= next_state;
   end

   always_comb begin
      next_state  = state;
      take_sample = 1'b0;
      load_out    = 1'b0;
      case (state)
         COLLECT: begin
            take_sample = 1'b1;
            if (cnt == LAST_CNT) next_state = OUTPUT;
         end
         OUTPUT: begin
            load_out = 1'b1;
`ifdef OBB_CONTINUOUS_EN
            next_state = COLLECT;
`else
            next_state = HOLD;
`endif
         end
         HOLD:    next_state = HOLD;
         default: next_state = COLLECT;
      endcase
   end

   // ---------------------------------------------------------------------
   // Sample counter and running min/max. NPTS is a power of two, so the
   // counter wraps to 0 on its own after the last sample, which lines it
   // up for the next frame in continuous mode.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         min_x <= '0; max_x <= '0;
         min_y <= '0; max_y <= '0;
         min_z <= '0; max_z <= '0;
      end else if (take_sample) begin
         cnt <= cnt + 1'b1;
         if (cnt == '0) begin
            min_x <= $signed(data_in_x); max_x <= $signed(data_in_x);
            min_y <= $signed(data_in_y); max_y <= $signed(data_in_y);
            min_z <= $signed(data_in_z); max_z <= $signed(data_in_z);
         end else begin
            // Strict compares: equal values leave the registers alone.
            if ($signed(data_in_x) < min_x) min_x <= $signed(data_in_x);
            if ($signed(data_in_x) > max_x) max_x <= $signed(data_in_x);
            if ($signed(data_in_y) < min_y) min_y <= $signed(data_in_y);
            if ($signed(data_in_y) > max_y) max_y <= $signed(data_in_y);
            if ($signed(data_in_z) < min_z) min_z <= $signed(data_in_z);
            if ($signed(data_in_z) > max_z) max_z <= $signed(data_in_z);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Corner registers. Corner index bit0/1/2 picks max (1) or min (0) for
   // x/y/z respectively; values are sign-extended from IW to OW bits.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 8; k++) begin
            cx[k] <= '0;
            cy[k] <= '0;
            cz[k] <= '0;
         end
      end else if (load_out) begin
         for (int k = 0; k < 8; k++) begin
            cx[k] <= (k[0]) ? {{EXT{max_x[IW-1]}}, max_x} : {{EXT{min_x[IW-1]}}, min_x};
            cy[k] <= (k[1]) ? {{EXT{max_y[IW-1]}}, max_y} : {{EXT{min_y[IW-1]}}, min_y};
            cz[k] <= (k[2]) ? {{EXT{max_z[IW-1]}}, max_z} : {{EXT{min_z[IW-1]}}, min_z};
         end
      end
   end

   assign data_out_x1 = cx[0]; assign data_out_y1 = cy[0]; assign data_out_z1 = cz[0];
   assign data_out_x2 = cx[1]; assign data_out_y2 = cy[1]; assign data_out_z2 = cz[1];
   assign data_out_x3 = cx[2]; assign data_out_y3 = cy[2]; assign data_out_z3 = cz[2];
   assign data_out_x4 = cx[3]; assign data_out_y4 = cy[3]; assign data_out_z4 = cz[3];
   assign data_out_x5 = cx[4]; assign data_out_y5 = cy[4]; assign data_out_z5 = cz[4];
   assign data_out_x6 = cx[5]; assign data_out_y6 = cy[5]; assign data_out_z6 = cz[5];
   assign data_out_x7 = cx[6]; assign data_out_y7 = cy[6]; assign data_out_z7 = cz[6];
   assign data_out_x8 = cx[7]; assign data_out_y8 = cy[7]; assign data_out_z8 = cz[7];

endmodule
`default_nettype wire

// File: tb/tb_obb_top_level.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obb_top_level
//  Purpose  : Directed self-checking bench for obb_top_level (default build).
//             Drives reset, reference, hold, extreme, constant and
//             mid-frame-reset frames and compares the 24 corner outputs
//             against hand-computed min/max values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_obb_top_level;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [9:0] data_in_x = '0, data_in_y = '0, data_in_z = '0;
   logic [16:0] ox [0:7];
   logic [16:0] oy [0:7];
   logic [16:0] oz [0:7];

   always #5 clk = ~clk;

   obb_top_level #(.NPTS(16), .IW(10), .OW(17)) dut (
      .clk(clk), .rst(rst),
      .data_in_x(data_in_x), .data_in_y(data_in_y), .data_in_z(data_in_z),
      .data_out_x1(ox[0]), .data_out_y1(oy[0]), .data_out_z1(oz[0]),
      .data_out_x2(ox[1]), .data_out_y2(oy[1]), .data_out_z2(oz[1]),
      .data_out_x3(ox[2]), .data_out_y3(oy[2]), .data_out_z3(oz[2]),
      .data_out_x4(ox[3]), .data_out_y4(oy[3]), .data_out_z4(oz[3]),
      .data_out_x5(ox[4]), .data_out_y5(oy[4]), .data_out_z5(oz[4]),
      .data_out_x6(ox[5]), .data_out_y6(oy[5]), .data_out_z6(oz[5]),
      .data_out_x7(ox[6]), .data_out_y7(oy[6]), .data_out_z7(oz[6]),
      .data_out_x8(ox[7]), .data_out_y8(oy[7]), .data_out_z8(oz[7])
   );

   int n_checks = 0;
   int n_pass   = 0;

   int fx [16];
   int fy [16];
   int fz [16];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   function automatic logic any_out_nonzero();
      logic r = 1'b0;
      for (int k = 0; k < 8; k++) r = r | (|ox[k]) | (|oy[k]) | (|oz[k]);
      return r;
   endfunction

   // Feeds fx/fy/fz on edges 1..16 (outputs must still be 0 after each),
   // then lets edge 17 happen with an unrelated input value.
   task automatic run_frame(input string tag);
      for (int i = 0; i < 16; i++) begin
         data_in_x = 10'(fx[i]);
         data_in_y = 10'(fy[i]);
         data_in_z = 10'(fz[i]);
         step();
         check_val($sformatf("%s_zero_e%0d", tag, i + 1), {31'b0, any_out_nonzero()}, 32'd0);
      end
      data_in_x = 10'(0); data_in_y = 10'(0); data_in_z = 10'(0);
      step();
   endtask

   task automatic check_corners(input string tag, input int xmn, input int xmx,
                                input int ymn, input int ymx, input int zmn, input int zmx);
      for (int k = 0; k < 8; k++) begin
         check_val($sformatf("%s_c%0d_x", tag, k + 1), {15'b0, ox[k]}, {15'b0, 17'(k[0] ? xmx : xmn)});
         check_val($sformatf("%s_c%0d_y", tag, k + 1), {15'b0, oy[k]}, {15'b0, 17'(k[1] ? ymx : ymn)});
         check_val($sformatf("%s_c%0d_z", tag, k + 1), {15'b0, oz[k]}, {15'b0, 17'(k[2] ? zmx : zmn)});
      end
   endtask

   task automatic load_reference();
      fx = '{216, 25, -70, 64, 94, 58, -49, -365, 18, -192, -348, 138, 84, 19, 197, 269};
      fy = '{80, 67, 133, 28, 222, 19, -18, -77, -29, 197, 297, -197, 38, -87, -289, -48};
      fz = '{-98, 62, 300, 0, -80, 72, -28, -28, -17, 284, 25, 91, -9, 87, 19, 59};
   endtask

   initial begin
      // Reset: 5 cycles high, all outputs 0.
      do_reset(5);
      check_val("reset_all_zero", {31'b0, any_out_nonzero()}, 32'd0);
      check_val("reset_x1", {15'b0, ox[0]}, 32'd0);
      check_val("reset_z8", {15'b0, oz[7]}, 32'd0);

      // Reference frame.
      load_reference();
      run_frame("ref");
      check_val("ref_x1_literal", {15'b0, ox[0]}, {15'b0, 17'h1FE93});
      check_corners("ref", -365, 269, -289, 297, -98, 300);

      // Hold: inputs ignored for 250 cycles.
      data_in_x = 10'(269); data_in_y = 10'(-48); data_in_z = 10'(59);
      repeat (250) step();
      data_in_x = 10'(-512); data_in_y = 10'(511); data_in_z = 10'(-512);
      repeat (20) step();
      check_corners("hold", -365, 269, -289, 297, -98, 300);

      // Extremes: all -512 except one 511 per axis at different positions.
      do_reset(2);
      check_val("ext_reset_zero", {31'b0, any_out_nonzero()}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         fx[i] = (i == 0)  ? 511 : -512;
         fy[i] = (i == 7)  ? 511 : -512;
         fz[i] = (i == 15) ? 511 : -512;
      end
      run_frame("ext");
      check_val("ext_x1_literal", {15'b0, ox[0]}, {15'b0, 17'h1FE00});
      check_val("ext_z8_literal", {15'b0, oz[7]}, {15'b0, 17'h001FF});
      check_corners("ext", -512, 511, -512, 511, -512, 511);

      // Constant frame.
      do_reset(1);
      for (int i = 0; i < 16; i++) begin
         fx[i] = 7; fy[i] = -3; fz[i] = 0;
      end
      run_frame("const");
      check_val("const_y1_literal", {15'b0, oy[0]}, {15'b0, 17'h1FFFD});
      check_corners("const", 7, 7, -3, -3, 0, 0);

      // Mid-frame reset: 9 extreme samples discarded, then reference frame.
      do_reset(1);
      for (int i = 0; i < 9; i++) begin
         data_in_x = 10'((i % 2) ? 500 : -500);
         data_in_y = 10'((i % 2) ? -511 : 511);
         data_in_z = 10'((i % 2) ? 400 : -400);
         step();
      end
      do_reset(1);
      check_val("mid_reset_zero", {31'b0, any_out_nonzero()}, 32'd0);
      load_reference();
      run_frame("mid");
      check_corners("mid", -365, 269, -289, 297, -98, 300);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute time guard so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/obb_top_level.md
# obb_top_level

Streaming bounding-box corner generator for the collision-detection datapath. Accepts a frame of 16 signed 3-D points, one per clock, tracks per-axis minimum and maximum, then presents the 8 corner vertices of the enclosing box as 24 sign-extended 17-bit coordinates. Sits between the point-cloud source and the collision-test stage; downstream logic samples the corner outputs once the frame completes.

## Interface
- NPTS, 16: points per frame; power of two, at least 2.
- IW, 10: input coordinate width, two's complement.
- OW, 17: output coordinate width, two's complement, with OW > IW.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous and active-high.
- data_in_x, data_in_y, data_in_z  in  IW each  signed point coordinates, sampled every clock while collecting.
- data_out_xK, data_out_yK, data_out_zK (K = 1..8)  out  OW each  corner K coordinates, registered.

## Operation
- States: COLLECT, then OUTPUT, then HOLD. Reset enters COLLECT with the sample counter at 0.
- COLLECT: on every rising edge, the current data_in_* is taken as a sample and the counter increments.
  - Sample 0 loads both the running min and the running max for each axis.
  - Later samples update them with signed comparison: min = smaller, max = larger. Equal values leave the register unchanged.
  - After sample NPTS-1 is taken, go to OUTPUT.
- OUTPUT: one cycle. All 24 output registers load from the final min/max; then go to HOLD.
- Corner mapping: i = K-1.
  - bit0 of i selects x: 0 = min, 1 = max.
  - bit1 of i selects y the same way.
  - bit2 of i selects z the same way.
  - So corner 1 = (xmin, ymin, zmin) and corner 8 = (xmax, ymax, zmax).
- Each output is the IW-bit value sign-extended to OW bits. No arithmetic is applied, so overflow is impossible.
- HOLD: outputs stay stable and inputs are ignored until reset.
- There is no valid strobe. Consumers rely on the fixed latency below.

## Timing
- While rst is high at a rising edge: all outputs become 0, the counter and min/max registers clear, and the state becomes COLLECT.
- Reset has priority over everything, including reset in mid-frame or during OUTPUT. The partial frame is discarded.
- The first sample is the value present at the first rising edge with rst low.
- Samples are taken on edges 1..NPTS after reset release. Outputs update on edge NPTS+1 (edge 17 by default) and are visible after it.
- Outputs keep their reset value of 0 until that edge.
- The input is sampled on every edge during COLLECT. Stalling the source is not supported.

## Configuration
- OBB_CONTINUOUS_EN:
  - Defined: OUTPUT goes back to COLLECT instead of HOLD, and the next input is sample 0 of a new frame. Outputs hold the previous frame's corners until the next OUTPUT cycle, which falls every NPTS+1 edges.
  - Undefined (default): single frame, then HOLD until reset.

## Test plan
- Reset: hold rst high for 5 cycles -> all 24 outputs are 0; outputs stay 0 through edge 16 of the following frame.
- Reference frame:
  - Stimulus, x: 216,25,-70,64,94,58,-49,-365,18,-192,-348,138,84,19,197,269.
  - Stimulus, y: 80,67,133,28,222,19,-18,-77,-29,197,297,-197,38,-87,-289,-48.
  - Stimulus, z: -98,62,300,0,-80,72,-28,-28,-17,284,25,91,-9,87,19,59.
  - Required on edge 17: corner1 = (-365,-289,-98); corner2 = (269,-289,-98); corner5 = (-365,-289,300); corner8 = (269,297,300). -365 appears as 17'h1FE93.
- Hold: after the reference frame, keep the input at (269,-48,59) for 250 cycles -> outputs unchanged (default build).
- Extremes: a frame that is all -512 except one point at 511 on each axis -> min = -512, max = 511 on every axis. All 8 corners are correct, with the sign extension verified.
- Constant frame: all 16 points = (7,-3,0) -> all 8 corners = (7,-3,0).
- Mid-frame reset: assert rst after 9 samples, then send the reference frame -> outputs match the reference result exactly, with no contamination from the discarded points.
